// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: grant/owner encoding used by the
// arbiter FSM and by anything that inspects its debug state.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-response valid delay line: a mem_ren beat re-emerges as a response
// valid exactly RD_LAT cycles later, independent of the arbiter state.
module ram_arb_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_valid,
    output logic o_valid
);

    logic [RD_LAT-1:0] r_sr;

    generate
        if (RD_LAT == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (!rstn) r_sr <= '0;
                else       r_sr <= i_valid;
            end
        end else begin : g_many
            always_ff @(posedge clk) begin
                if (!rstn) r_sr <= '0;
                else       r_sr <= {r_sr[RD_LAT-2:0], i_valid};
            end
        end
    endgenerate

    // Gated by reset so a beat in flight never surfaces while reset is held.
    assign o_valid = r_sr[RD_LAT-1] & rstn;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a burst read
// requester and a burst write requester, with a fixed-latency read return.
//
// Handshake: a beat transfers in any cycle where req_valid && req_ready are
// both high at the rising clk edge; ready depends only on the registered
// grant, never on valid, and a requester may drop valid between beats
// without losing its grant.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST      = 32,
    parameter int RD_LAT         = 1,
    localparam int LSB = $clog2(AXI_WIDTH) - 3,
    localparam int AW  = AXI_ADDR_WIDTH - LSB,
    localparam int SW  = AXI_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [AW-1:0]        rd_req_addr,
    input  logic                 rd_req_last,
    output logic                 rd_rsp_valid,
    output logic [AXI_WIDTH-1:0] rd_rsp_data,
    input  logic                 wr_req_valid,
    output logic                 wr_req_ready,
    input  logic [AW-1:0]        wr_req_addr,
    input  logic [AXI_WIDTH-1:0] wr_req_data,
    input  logic [SW-1:0]        wr_req_strb,
    input  logic                 wr_req_last,
    output logic                 mem_ren,
    output logic                 mem_wen,
    output logic [AW-1:0]        mem_addr,
    output logic [AXI_WIDTH-1:0] mem_wdata,
    output logic [SW-1:0]        mem_wstrb,
    input  logic [AXI_WIDTH-1:0] mem_rdata,
    output logic                 busy,
    output logic                 err_burst,
    output arb_state_t           dbg_state
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    r_state, w_next;
    arb_state_t    r_last_owner, w_next_owner;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic          w_rd_ready, w_wr_ready, w_ren, w_wen, w_beat, w_last;
    logic [CW-1:0] w_cnt_inc;
    logic          w_max, w_end;

    assign w_rd_ready = rstn & (r_state == RD);
    assign w_wr_ready = rstn & (r_state == WR);
    assign w_ren      = rd_req_valid & w_rd_ready;
    assign w_wen      = wr_req_valid & w_wr_ready;
    assign w_beat     = w_ren | w_wen;
    assign w_last     = (r_state == WR) ? wr_req_last : rd_req_last;
    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_max      = (w_cnt_inc == CW'(MAX_BURST));
    assign w_end      = w_beat & (w_last | w_max);

    // At burst end the other side gets first refusal, then the same side.
    always_comb begin
        w_next       = r_state;
        w_next_owner = r_last_owner;
        case (r_state)
            IDLE: begin
                if (rd_req_valid && wr_req_valid)
                    w_next = (r_last_owner == WR) ? RD : WR;
                else if (rd_req_valid)
                    w_next = RD;
                else if (wr_req_valid)
                    w_next = WR;
            end
            RD: begin
                if (w_end) begin
                    w_next_owner = RD;
                    if (wr_req_valid)      w_next = WR;
                    else if (rd_req_valid) w_next = RD;
                    else                   w_next = IDLE;
                end
            end
            WR: begin
                if (w_end) begin
                    w_next_owner = WR;
                    if (rd_req_valid)      w_next = RD;
                    else if (wr_req_valid) w_next = WR;
                    else                   w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_last_owner <= WR;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_last_owner <= w_next_owner;
            if (w_end)       r_cnt <= '0;
            else if (w_beat) r_cnt <= w_cnt_inc;
            if (w_end && w_max && !w_last) r_err <= 1'b1;
        end
    end

    ram_arb_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (w_ren),
        .o_valid (rd_rsp_valid)
    );

    assign rd_rsp_data  = mem_rdata;
    assign rd_req_ready = w_rd_ready;
    assign wr_req_ready = w_wr_ready;
    assign mem_ren      = w_ren;
    assign mem_wen      = w_wen;
    assign mem_addr     = (r_state == WR) ? wr_req_addr : rd_req_addr;
    assign mem_wdata    = wr_req_data;
    assign mem_wstrb    = w_wen ? wr_req_strb : '0;
    assign busy         = rstn & (r_state != IDLE);
    assign err_burst    = rstn & r_err;
    assign dbg_state    = rstn ? r_state : IDLE;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: random and directed burst traffic from both
// requesters, scoreboarded at the memory port and the read-response port.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AXI_WIDTH      = 128;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int MAX_BURST      = 32;
    localparam int RD_LAT         = 3;
    localparam int LSB = $clog2(AXI_WIDTH) - 3;
    localparam int AW  = AXI_ADDR_WIDTH - LSB;
    localparam int SW  = AXI_WIDTH / 8;
    localparam int WPK = AW + SW + AXI_WIDTH;
    localparam int TMO = 3000;

    logic                 clk, rstn;
    logic                 rd_req_valid, rd_req_ready, rd_req_last;
    logic [AW-1:0]        rd_req_addr;
    logic                 rd_rsp_valid;
    logic [AXI_WIDTH-1:0] rd_rsp_data;
    logic                 wr_req_valid, wr_req_ready, wr_req_last;
    logic [AW-1:0]        wr_req_addr;
    logic [AXI_WIDTH-1:0] wr_req_data;
    logic [SW-1:0]        wr_req_strb;
    logic                 mem_ren, mem_wen;
    logic [AW-1:0]        mem_addr;
    logic [AXI_WIDTH-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0]        mem_wstrb;
    logic                 busy, err_burst;
    arb_state_t           dbg_state;

    ram_port_arbiter #(
        .AXI_WIDTH(AXI_WIDTH), .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
        .MAX_BURST(MAX_BURST), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_last(rd_req_last),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
        .wr_req_strb(wr_req_strb), .wr_req_last(wr_req_last),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy), .err_burst(err_burst), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AXI_WIDTH-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] h;
        h = ({4'h0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
        return {h, ~h, h ^ 32'hFFFF0000, h + 32'd1};
    endfunction

    // Memory returns the data for the address it saw RD_LAT cycles ago.
    logic [AW-1:0] dl [RD_LAT];
    always @(posedge clk) begin
        dl[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
    end
    assign mem_rdata = pat(dl[RD_LAT-1]);

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [AW-1:0]        exp_raddr_q[$];
    logic [AXI_WIDTH-1:0] exp_rdata_q[$];
    logic [WPK-1:0]       exp_w_q[$];
    int   lat_q[$];
    int   ren_cyc_q[$], wen_cyc_q[$], rsp_cyc_q[$];
    logic err_at_wen_q[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event expected none", nm);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn) begin
            chk("ren_wen_exclusive", 256'(mem_ren & mem_wen), 256'(0));
            if (!mem_wen) chk("wstrb_idle", 256'(mem_wstrb), 256'(0));
            if (mem_ren) begin
                ren_cyc_q.push_back(cyc);
                lat_q.push_back(cyc);
                if (exp_raddr_q.size() == 0) fail_now("unexpected_mem_ren");
                else chk("mem_raddr", 256'(mem_addr), 256'(exp_raddr_q.pop_front()));
            end
            if (mem_wen) begin
                wen_cyc_q.push_back(cyc);
                err_at_wen_q.push_back(err_burst);
                if (exp_w_q.size() == 0) fail_now("unexpected_mem_wen");
                else chk("mem_write", 256'({mem_addr, mem_wstrb, mem_wdata}),
                         256'(exp_w_q.pop_front()));
            end
            if (rd_rsp_valid) begin
                rsp_cyc_q.push_back(cyc);
                if (exp_rdata_q.size() == 0 || lat_q.size() == 0) fail_now("unexpected_rsp");
                else begin
                    chk("rsp_data", 256'(rd_rsp_data), 256'(exp_rdata_q.pop_front()));
                    chk("rsp_latency", 256'(cyc), 256'(lat_q.pop_front() + RD_LAT));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rd_beat(input logic [AW-1:0] a, input logic last);
        int waited = 0;
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_last = last;
        exp_raddr_q.push_back(a);
        exp_rdata_q.push_back(pat(a));
        @(negedge clk);
        while (!rd_req_ready && waited < TMO) begin @(negedge clk); waited++; end
        if (!rd_req_ready) fail_now("rd_accept_timeout");
        @(posedge clk); #1;
        rd_req_valid = 1'b0; rd_req_last = 1'b0;
    endtask

    task automatic wr_beat(input logic [AW-1:0] a, input logic last);
        int waited = 0;
        logic [AXI_WIDTH-1:0] d;
        logic [SW-1:0] s;
        for (int k = 0; k < AXI_WIDTH / 32; k++) d[32*k +: 32] = $urandom;
        s = SW'($urandom_range(1, (1 << SW) - 1));
        wr_req_valid = 1'b1; wr_req_addr = a; wr_req_last = last;
        wr_req_data = d; wr_req_strb = s;
        exp_w_q.push_back({a, s, d});
        @(negedge clk);
        while (!wr_req_ready && waited < TMO) begin @(negedge clk); waited++; end
        if (!wr_req_ready) fail_now("wr_accept_timeout");
        @(posedge clk); #1;
        wr_req_valid = 1'b0; wr_req_last = 1'b0;
    endtask

    task automatic rd_burst(input logic [AW-1:0] base, input int len, input logic use_last,
                            input int gap_at, input int gap_len);
        for (int i = 0; i < len; i++) begin
            rd_beat(base + AW'(i), use_last && (i == len - 1));
            if (i == gap_at && i < len - 1 && gap_len > 0) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wr_burst(input logic [AW-1:0] base, input int len, input logic use_last,
                            input int gap_at, input int gap_len);
        for (int i = 0; i < len; i++) begin
            wr_beat(base + AW'(i), use_last && (i == len - 1));
            if (i == gap_at && i < len - 1 && gap_len > 0) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        rd_req_valid = 1'b0; rd_req_last = 1'b0; wr_req_valid = 1'b0; wr_req_last = 1'b0;
        exp_raddr_q.delete(); exp_rdata_q.delete(); exp_w_q.delete(); lat_q.delete();
        ren_cyc_q.delete(); wen_cyc_q.delete(); rsp_cyc_q.delete(); err_at_wen_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic drain(input string nm);
        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        chk({nm, "_raddr_left"}, 256'(exp_raddr_q.size()), 256'(0));
        chk({nm, "_rdata_left"}, 256'(exp_rdata_q.size()), 256'(0));
        chk({nm, "_write_left"}, 256'(exp_w_q.size()), 256'(0));
    endtask

    // ---------------- test sequence ----------------
    int c0, n_rd, n_wr, nrsp0;
    logic [31:0] rnd;

    initial begin
        rstn = 1'b0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_last = 1'b0;
        wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_last = 1'b0;
        wr_req_data = '0; wr_req_strb = '0;
        repeat (3) @(posedge clk);
        #1;
        // Outputs while reset is held
        chk("rst_rd_ready", 256'(rd_req_ready), 256'(0));
        chk("rst_wr_ready", 256'(wr_req_ready), 256'(0));
        chk("rst_ren_wen", 256'({mem_ren, mem_wen}), 256'(0));
        chk("rst_rsp_valid", 256'(rd_rsp_valid), 256'(0));
        chk("rst_busy_err", 256'({busy, err_burst}), 256'(0));
        chk("rst_wstrb", 256'(mem_wstrb), 256'(0));
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_busy", 256'(busy), 256'(0));
        chk("idle_state", 256'(dbg_state), 256'(IDLE));

        // Simultaneous requests after reset: read wins, write follows back-to-back
        @(posedge clk); #1;
        c0 = cyc;
        fork
            rd_burst(AW'('h100), 4, 1'b1, -1, 0);
            wr_burst(AW'('h200), 4, 1'b1, -1, 0);
        join
        drain("tie");
        chk("tie_counts", 256'({ren_cyc_q.size(), wen_cyc_q.size()}), 256'({32'd4, 32'd4}));
        if (ren_cyc_q.size() == 4 && wen_cyc_q.size() == 4) begin
            chk("tie_rd_first", 256'(ren_cyc_q[0]), 256'(c0 + 1));
            chk("tie_rd_last", 256'(ren_cyc_q[3]), 256'(c0 + 4));
            chk("tie_wr_first", 256'(wen_cyc_q[0]), 256'(c0 + 5));
            chk("tie_wr_last", 256'(wen_cyc_q[3]), 256'(c0 + 8));
        end

        // Single read at 0x10: response exactly RD_LAT cycles later
        do_reset();
        rd_burst(AW'('h10), 1, 1'b1, -1, 0);
        drain("lat");
        chk("lat_rsp_count", 256'(rsp_cyc_q.size()), 256'(1));
        if (rsp_cyc_q.size() == 1 && ren_cyc_q.size() == 1)
            chk("lat_cycles", 256'(rsp_cyc_q[0] - ren_cyc_q[0]), 256'(RD_LAT));

        // Read stalls 3 cycles mid-burst with write waiting; switch with reads in flight
        do_reset();
        fork
            rd_burst(AW'('h300), 4, 1'b1, 1, 3);
            wr_burst(AW'('h400), 3, 1'b1, -1, 0);
        join
        drain("stall");
        chk("stall_counts", 256'({ren_cyc_q.size(), wen_cyc_q.size(), rsp_cyc_q.size()}),
            256'({32'd4, 32'd3, 32'd4}));
        if (ren_cyc_q.size() == 4 && wen_cyc_q.size() == 3) begin
            chk("stall_gap", 256'(ren_cyc_q[2] - ren_cyc_q[1]), 256'(4));
            chk("stall_wr_after_last", 256'(wen_cyc_q[0]), 256'(ren_cyc_q[3] + 1));
        end

        // Random bursts from both sides
        do_reset();
        n_rd = 0; n_wr = 0;
        fork
            for (int b = 0; b < 10; b++) begin
                int len;
                len = $urandom_range(1, 8);
                rnd = $urandom;
                n_rd += len;
                rd_burst(rnd[AW-1:0], len, 1'b1, $urandom_range(0, 7), $urandom_range(0, 2));
            end
            for (int b = 0; b < 10; b++) begin
                int len;
                logic [31:0] wa;
                len = $urandom_range(1, 8);
                wa = $urandom;
                n_wr += len;
                wr_burst(wa[AW-1:0], len, 1'b1, $urandom_range(0, 7), $urandom_range(0, 2));
            end
        join
        drain("rand");
        chk("rand_rd_beats", 256'(ren_cyc_q.size()), 256'(n_rd));
        chk("rand_wr_beats", 256'(wen_cyc_q.size()), 256'(n_wr));
        chk("rand_rsp_beats", 256'(rsp_cyc_q.size()), 256'(n_rd));
        chk("rand_no_err", 256'(err_burst), 256'(0));

        // Write burst without last: cut at MAX_BURST, read slips in, sticky error
        do_reset();
        fork
            wr_burst(AW'('h800), 40, 1'b0, -1, 0);
            begin
                int w = 0;
                while (wen_cyc_q.size() < 5 && w < TMO) begin @(negedge clk); w++; end
                if (wen_cyc_q.size() < 5) fail_now("ovf_wait_timeout");
                @(posedge clk); #1;
                rd_burst(AW'('h900), 2, 1'b1, -1, 0);
            end
        join
        drain("ovf");
        chk("ovf_counts", 256'({wen_cyc_q.size(), ren_cyc_q.size()}), 256'({32'd40, 32'd2}));
        if (wen_cyc_q.size() == 40 && ren_cyc_q.size() == 2) begin
            chk("ovf_rd_after_32", 256'(ren_cyc_q[0]), 256'(wen_cyc_q[MAX_BURST-1] + 1));
            chk("ovf_wr_resume", 256'(wen_cyc_q[MAX_BURST]), 256'(ren_cyc_q[1] + 1));
            chk("ovf_err_before", 256'(err_at_wen_q[MAX_BURST-1]), 256'(0));
            chk("ovf_err_after", 256'(err_at_wen_q[MAX_BURST]), 256'(1));
        end
        chk("ovf_err_sticky", 256'(err_burst), 256'(1));

        // Reset mid-burst with one read outstanding
        do_reset();
        chk("rst_clears_err", 256'(err_burst), 256'(0));
        rd_req_valid = 1'b1; rd_req_addr = AW'('h10); rd_req_last = 1'b0;
        exp_raddr_q.push_back(AW'('h10));
        exp_rdata_q.push_back(pat(AW'('h10)));
        @(negedge clk);
        @(negedge clk);
        chk("rst_beat_issued", 256'(mem_ren), 256'(1));
        @(posedge clk); #1;
        rstn = 1'b0; rd_req_valid = 1'b0;
        exp_rdata_q.delete(); lat_q.delete();
        @(negedge clk);
        chk("midrst_outputs", 256'({rd_req_ready, wr_req_ready, mem_ren, mem_wen,
                                    rd_rsp_valid, busy, err_burst}), 256'(0));
        chk("midrst_state", 256'(dbg_state), 256'(IDLE));
        @(posedge clk); #1;
        rstn = 1'b1;
        nrsp0 = rsp_cyc_q.size();
        repeat (RD_LAT + 3) @(negedge clk);
        chk("midrst_no_rsp", 256'(rsp_cyc_q.size()), 256'(nrsp0));
        chk("midrst_idle", 256'({busy, dbg_state}), 256'({1'b0, IDLE}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        fail_now("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
